// File: rtl/half_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : half_sub_pkg                                                |
// | Purpose: Shared types and the half-subtract function used by the     |
// |          half_sub slice. Holds the default counter width.            |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package half_sub_pkg;

  // Default width of the borrow event counter.
  localparam int CNT_W_DEFAULT = 8;

  // One-bit subtraction result: a - b = diff - 2*borrow.
  typedef struct packed {
    logic diff;
    logic borrow;
  } sub_res_t;

  // Pure half-subtract; X/Z on inputs propagate through the operators.
  function automatic sub_res_t half_sub_f(input logic a, input logic b);
    sub_res_t r;
    r.diff   = a ^ b;
    r.borrow = ~a & b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_sub_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : half_sub_core                                               |
// | Purpose: Purely combinational 1-bit half subtractor (a - b).         |
// |          Reusable as a building block for full subtractors.          |
// | Ports  : a, b        in  minuend, subtrahend                         |
// |          diff        out a ^ b                                       |
// |          borrow      out ~a & b                                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module half_sub_core
  import half_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  sub_res_t res;

  assign res    = half_sub_f(a, b);
  assign diff   = res.diff;
  assign borrow = res.borrow;

endmodule
`default_nettype wire

// File: rtl/half_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : half_sub                                                    |
// | Purpose: Half subtractor with combinational diff/borrow, a one-cycle |
// |          registered copy, and a saturating borrow-event counter.     |
// | Ports  : clk         in  rising-edge clock                           |
// |          rst         in  synchronous active-high reset               |
// |          a, b        in  minuend, subtrahend                         |
// |          diff        out combinational a ^ b                         |
// |          borrow      out combinational ~a & b                        |
// |          diff_q      out diff registered on clk                      |
// |          borrow_q    out borrow registered on clk                    |
// |          borrow_cnt  out edges that sampled borrow=1, saturating     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module half_sub
  import half_sub_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             diff,
  output logic             borrow,
  output logic             diff_q,
  output logic             borrow_q,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  half_sub_core u_core (
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow)
  );

  // Reset wins over a same-edge increment; counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= 1'b0;
      borrow_q   <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      diff_q   <= diff;
      borrow_q <= borrow;
      if (borrow && (borrow_cnt != CNT_MAX)) begin
        borrow_cnt <= borrow_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_half_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_half_sub                                                 |
// | Purpose: Self-checking bench for half_sub (CNT_W=8 and CNT_W=2).     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_half_sub;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       diff, borrow, diff_q, borrow_q;
  logic [7:0] borrow_cnt;
  logic       diff2, borrow2, diff_q2, borrow_q2;
  logic [1:0] borrow_cnt2;

  int compared;
  int mismatched;

  half_sub #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow     (borrow),
    .diff_q     (diff_q),
    .borrow_q   (borrow_q),
    .borrow_cnt (borrow_cnt)
  );

  half_sub #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .diff       (diff2),
    .borrow     (borrow2),
    .diff_q     (diff_q2),
    .borrow_q   (borrow_q2),
    .borrow_cnt (borrow_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic diff;
    logic borrow;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change inputs away from the active edge.
  task automatic drive(input logic r, input logic av, input logic bv);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    vecs[0] = '{a: 1'b0, b: 1'b0, diff: 1'b0, borrow: 1'b0};
    vecs[1] = '{a: 1'b0, b: 1'b1, diff: 1'b1, borrow: 1'b1};
    vecs[2] = '{a: 1'b1, b: 1'b0, diff: 1'b1, borrow: 1'b0};
    vecs[3] = '{a: 1'b1, b: 1'b1, diff: 1'b0, borrow: 1'b0};

    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;

    // Combinational truth table, independent of clock.
    for (int i = 0; i < 4; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #10;
      check($sformatf("diff[%0d]", i), int'(diff), int'(vecs[i].diff));
      check($sformatf("borrow[%0d]", i), int'(borrow), int'(vecs[i].borrow));
      check($sformatf("identity[%0d]", i),
            int'(diff) - 2 * int'(borrow), int'(vecs[i].a) - int'(vecs[i].b));
      check($sformatf("core2_diff[%0d]", i), int'(diff2), int'(vecs[i].diff));
    end

    // Reset held for two edges; combinational path still follows a/b.
    drive(1'b1, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_diff_q", int'(diff_q), 0);
    check("rst_borrow_q", int'(borrow_q), 0);
    check("rst_cnt", int'(borrow_cnt), 0);
    check("rst_cnt2", int'(borrow_cnt2), 0);
    check("rst_comb_diff", int'(diff), 1);
    check("rst_comb_borrow", int'(borrow), 1);
    a = 1'b1;
    b = 1'b0;
    #1;
    check("rst_comb_diff_b", int'(diff), 1);
    check("rst_comb_borrow_b", int'(borrow), 0);

    // Borrow held six edges: wide counter climbs, 2-bit counter saturates.
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("cnt_edge%0d", k), int'(borrow_cnt), k);
      check($sformatf("cnt2_edge%0d", k), int'(borrow_cnt2), (k < 3) ? k : 3);
      check($sformatf("borrow_q_edge%0d", k), int'(borrow_q), 1);
      check($sformatf("diff_q_edge%0d", k), int'(diff_q), 1);
    end

    // No borrow: counters hold, registered copies follow a=1,b=1.
    drive(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("hold_cnt", int'(borrow_cnt), 6);
      check("hold_cnt2", int'(borrow_cnt2), 3);
      check("hold_borrow_q", int'(borrow_q), 0);
      check("hold_diff_q", int'(diff_q), 0);
    end

    // a=1,b=0: diff_q=1, borrow_q=0, one-cycle latency.
    drive(1'b0, 1'b1, 1'b0);
    #1;
    check("lat_diff_q_before", int'(diff_q), 0);
    tick();
    check("lat_diff_q_after", int'(diff_q), 1);
    check("lat_borrow_q", int'(borrow_q), 0);

    // Reset coinciding with borrow=1 must clear, not increment.
    drive(1'b1, 1'b0, 1'b1);
    tick();
    check("rstpri_cnt", int'(borrow_cnt), 0);
    check("rstpri_cnt2", int'(borrow_cnt2), 0);
    check("rstpri_borrow_q", int'(borrow_q), 0);
    check("rstpri_diff_q", int'(diff_q), 0);
    check("rstpri_comb_borrow", int'(borrow), 1);

    // Counting resumes from zero after reset release.
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check("resume_cnt", int'(borrow_cnt), 1);
    check("resume_cnt2", int'(borrow_cnt2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
